// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, oversampled start/data/parity/stop
// sampling, and a one-clock rx_done strobe with parity and framing flags.
module uart_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_i,
   input  logic                  rx_tick_i,
   input  logic                  parity_en_i,
   input  logic                  odd_r_even_parity_i,
   output logic [DATA_WIDTH-1:0] data_out_o,
   output logic                  rx_done_o,
   output logic                  parity_err_o,
   output logic                  frame_err_o,
   output logic                  busy_o,
   output logic [2:0]            state_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  rx_meta_q, rx_s_q;
   logic [TW-1:0]         tick_q, tick_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_en_q, par_en_d;
   logic                  par_even_q, par_even_d;
   logic                  perr_q, perr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;
   logic                  perr_out_q, perr_out_d;
   logic                  ferr_q, ferr_d;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_even_q <= 1'b0;
         perr_q     <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_even_q <= par_even_d;
         perr_q     <= perr_d;
         data_q     <= data_d;
         done_q     <= done_d;
         perr_out_q <= perr_out_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_even_d = par_even_q;
      perr_d     = perr_q;
      data_d     = data_q;
      done_d     = 1'b0;
      perr_out_d = perr_out_q;
      ferr_d     = ferr_q;
      case (state_q)
         S_IDLE: begin
            // Start detection runs every clk; frame config is frozen here.
            if (!rx_s_q) begin
               state_d    = S_START;
               tick_d     = '0;
               par_en_d   = parity_en_i;
               par_even_d = odd_r_even_parity_i;
            end
         end
         S_START: begin
            if (rx_tick_i) begin
               if (tick_q == TICK_MID) begin
                  if (!rx_s_q) begin
                     state_d = S_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                     perr_d  = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (rx_tick_i) begin
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = par_en_q ? S_PARITY : S_STOP;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (rx_tick_i) begin
               if (tick_q == TICK_LAST) begin
                  perr_d  = rx_s_q != (par_even_q ? ^shift_q : ~^shift_q);
                  tick_d  = '0;
                  state_d = S_STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            // Leaving at mid-stop gives half a bit of margin for the next start.
            if (rx_tick_i) begin
               if (tick_q == TICK_LAST) begin
                  data_d     = shift_q;
                  ferr_d     = !rx_s_q;
                  perr_out_d = par_en_q & perr_q;
                  done_d     = 1'b1;
                  tick_d     = '0;
                  state_d    = S_IDLE;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data_out_o   = data_q;
   assign rx_done_o    = done_q;
   assign parity_err_o = perr_out_q;
   assign frame_err_o  = ferr_q;
   assign busy_o       = (state_q != S_IDLE);
   assign state_o      = state_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART RX path; counterpart of the team's UART transmitter.
- Samples serial line `rx` using an oversampling tick from the shared baud generator.
- Frame format: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit.
- Delivers the parallel byte with a one-cycle `rx_done` strobe plus parity/framing error flags to the host-side logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 16, `rx_tick` pulses per bit period; must be even and ≥4.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line, asynchronous to clk; idle high.
- rx_tick  input  1  oversample strobe, one clk wide, OVERSAMPLE per bit.
- parity_en  input  1  1 = frame carries a parity bit.
- odd_r_even_parity  input  1  1 = even parity (parity bit = XOR of data); 0 = odd parity (parity bit = XNOR of data).
- data_out  output  DATA_WIDTH  last received data word.
- rx_done  output  1  one-clk pulse when a frame completes (good or errored).
- parity_err  output  1  parity mismatch on last frame.
- frame_err  output  1  stop bit sampled low on last frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; sync flops=1.
  - data_out=0; rx_done=0; parity_err=0; frame_err=0; busy=0.
  - Tick, bit and shift registers cleared.
- Synchroniser: rx passes through 2 flops (reset value 1). All decisions use the synchronised value `rx_s`.
- Counters:
  - tick_cnt: $clog2(OVERSAMPLE) bits; advances only on rx_tick.
  - bit_cnt: $clog2(DATA_WIDTH)+1 bits.
- IDLE:
  - On `rx_s==0` → START; tick_cnt=0.
  - Latch parity_en and odd_r_even_parity for the whole frame. Mid-frame changes on these inputs are ignored.
- START:
  - On the rx_tick where tick_cnt==OVERSAMPLE/2-1 (bit centre):
    - If `rx_s==0` → DATA; tick_cnt=0; bit_cnt=0.
    - Else → IDLE (glitch rejected, no rx_done, flags unchanged).
- DATA:
  - On the rx_tick where tick_cnt==OVERSAMPLE-1, sample `rx_s`. Shift right, inserting at MSB, so the first bit received ends at bit 0. Then tick_cnt=0 and bit_cnt+1.
  - After the DATA_WIDTH-th sample → PARITY if latched parity_en, else STOP.
- PARITY:
  - Sample at tick_cnt==OVERSAMPLE-1.
  - perr = sampled bit ≠ expected. Expected = ^shift for even, ~^shift for odd.
  - Then → STOP.
- STOP:
  - Sample at tick_cnt==OVERSAMPLE-1 (stop-bit centre).
  - In that same clk:
    - data_out←shift.
    - frame_err←(rx_s==0).
    - parity_err←perr (0 if parity disabled).
    - rx_done←1.
    - state→IDLE.
  - Returning at mid-stop allows the next start edge to be detected with half a bit of margin.
- rx_done: high exactly one clk, registered. Cleared the next clk regardless of rx_tick.
- Flags and data_out hold until the next rx_done. They update even on an errored frame.
- Ticks/clk: no action on clk cycles without rx_tick, except the IDLE start detection (per-clk) and the rx_done clear.
- Break (line held low): produces a frame with data=0 and frame_err=1. The receiver then re-enters START immediately if rx_s is still 0. This is accepted behaviour.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, partial data discarded.
- Latency: rx_done asserts 2 clk (synchroniser) plus the stop-centre tick after the line's stop-bit centre.

Test Plan:
- Nominal frame: rx_tick every 4 clk, OVERSAMPLE=16, parity off; send 0xA5 with stop=1 → single rx_done pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low after done.
- Even parity: parity_en=1, odd_r_even_parity=1; send 0x3C with parity bit 0 → data_out=0x3C, parity_err=0.
- Parity error: same setup, parity bit 1 → rx_done pulse, parity_err=1. Then send 0x01 with odd parity (odd_r_even_parity=0), parity bit 0 → parity_err returns to 0.
- Framing error: send 0x55 with stop bit driven 0 → data_out=0x55, frame_err=1.
- Glitch rejection: rx low for 5 ticks then high → no rx_done, busy returns 0, data_out unchanged.
- Reset mid-frame and back-to-back:
  - Assert rst during the 4th data bit → outputs reset, busy=0.
  - After release, send two frames 0x12 then 0xFE with no idle gap → two rx_done pulses, data_out 0x12 then 0xFE, no errors.
